pipe_hazard_ctrl: RTL



---
 rtl/pipe_hazard_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall / flush / exception sequencer for the 5-stage MIPS pipeline
// (F/D/E/M/W). It covers three kinds of hold-up for the instruction in D:
//   * data hazards, from Tuse (D-stage consumer) against Tnew (E/M producer)
//   * multiply/divide unit occupancy, tracked by an internal countdown
//   * eret in D while an mtc0 to EPC is still in E or M
// An exception/interrupt request from CP0 overrides all of these. Every
// pipeline register then loads handler state through pipe_req.
//
// Optional feature: define PIPE_CTRL_STATS_EN to add the stall_cycles and
// req_count statistics outputs. With the macro undefined those ports and
// their counters do not exist, and the core behaviour is the same.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   D_rs, D_rt         source registers of the instruction in D
//   D_use_rs/_rt       D instruction reads rs / rt
//   D_tuse_rs/_rt      Tuse of rs / rt (0..2, 3 = unused)
//   E_a3, M_a3         destination register in E / M (0 = none)
//   E_tnew, M_tnew     remaining Tnew of the E / M instruction
//   D_is_md            D instruction uses the MDU
//   E_md_start         00 none, 01 mult-class start, 10 div-class start
//   D_eret             eret in D
//   E_mtc0_epc/M_...   mtc0 to EPC in E / M
//   exc_req            CP0 exception / interrupt request (M stage)
//   F_en, D_en         F/D register write enables
//   E_stall            D/E register stall (insert bubble, keep pc)
//   pipe_req           Req to all pipeline registers
//   md_start_ok        MDU may latch E_md_start this cycle
//   md_busy            MDU occupied (registered)
//   md_cnt             remaining MDU busy cycles (registered)
//   stall_cycles       [stats] cycles stalled without a request, saturating
//   req_count          [stats] cycles with exc_req, wrapping
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic             D_use_rs,
  input  logic             D_use_rt,
  input  logic [1:0]       D_tuse_rs,
  input  logic [1:0]       D_tuse_rt,
  input  logic [4:0]       E_a3,
  input  logic [4:0]       M_a3,
  input  logic [1:0]       E_tnew,
  input  logic [1:0]       M_tnew,
  input  logic             D_is_md,
  input  logic [1:0]       E_md_start,
  input  logic             D_eret,
  input  logic             E_mtc0_epc,
  input  logic             M_mtc0_epc,
  input  logic             exc_req,
  output logic             F_en,
  output logic             D_en,
  output logic             E_stall,
  output logic             pipe_req,
  output logic             md_start_ok,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [15:0]      req_count
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_MUL = 2'd1,
    BUSY_DIV = 2'd2
  } state_t;

  localparam logic [1:0] MD_START_MUL = 2'b01;
  localparam logic [1:0] MD_START_DIV = 2'b10;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t state;

  logic stall_rs;
  logic stall_rt;
  logic stall_md;
  logic stall_eret;
  logic stall;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  // A source stalls when a producer still in E or M needs more cycles (Tnew)
  // than the consumer can wait (Tuse). $0 is hard-wired, so it never waits.
  // A Tuse of 3 can never be exceeded by a 2-bit Tnew, so "unused" needs no
  // special case.
  always_comb begin
    // NOTE: every signal written here gets a value before any condition, so
    // no path can leave it unassigned and infer a latch.
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    if (D_use_rs && (D_rs != 5'd0)) begin
      stall_rs = ((E_a3 == D_rs) && (E_tnew > D_tuse_rs)) ||
                 ((M_a3 == D_rs) && (M_tnew > D_tuse_rs));
    end
    if (D_use_rt && (D_rt != 5'd0)) begin
      stall_rt = ((E_a3 == D_rt) && (E_tnew > D_tuse_rt)) ||
                 ((M_a3 == D_rt) && (M_tnew > D_tuse_rt));
    end
  end

  // An MD instruction in D waits while the unit is busy, and also while a
  // start sits in E. The registered md_busy does not see that start until
  // the next edge.
  assign stall_md   = D_is_md && (md_busy || (E_md_start != 2'b00));

  // eret reads EPC in D. It must wait until a pending mtc0 EPC has written it.
  assign stall_eret = D_eret && (E_mtc0_epc || M_mtc0_epc);

  assign stall      = stall_rs || stall_rt || stall_md || stall_eret;

  // ---------------------------------------------------------------------------
  // Pipeline register controls
  // ---------------------------------------------------------------------------
  // Under pipe_req the registers load handler state and ignore F_en/D_en.
  // E_stall is still masked so that the D/E register sees a single command.
  assign F_en     = !stall;
  assign D_en     = !stall;
  assign E_stall  = stall && !exc_req;
  assign pipe_req = exc_req;

  // A start is accepted only from IDLE. A start seen while busy cannot occur
  // in a legal flow; if one does, it is ignored and the countdown stays put.
  assign md_start_ok = (E_md_start != 2'b00) && !exc_req && (state == IDLE);

  // ---------------------------------------------------------------------------
  // MDU occupancy FSM
  // ---------------------------------------------------------------------------
  // The load edge sets md_cnt to N. The count then runs N..1 with md_busy
  // high, so the unit is busy for exactly N cycles. An exception does not
  // cancel an operation already in flight; it only blocks new starts.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments, so every register
    // here samples the values from before this edge, whatever the order.
    if (reset) begin
      state   <= IDLE;
      md_cnt  <= '0;
      md_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (md_start_ok && (E_md_start == MD_START_MUL)) begin
            state   <= BUSY_MUL;
            md_cnt  <= MULT_LOAD;
            md_busy <= 1'b1;
          end else if (md_start_ok && (E_md_start == MD_START_DIV)) begin
            state   <= BUSY_DIV;
            md_cnt  <= DIV_LOAD;
            md_busy <= 1'b1;
          end
        end

        BUSY_MUL, BUSY_DIV: begin
          // A count of 0 while busy is unreachable. It is handled like the
          // last cycle so the FSM can never stick in a busy state.
          if (md_cnt <= CNT_ONE) begin
            state   <= IDLE;
            md_cnt  <= '0;
            md_busy <= 1'b0;
          end else begin
            md_cnt  <= md_cnt - CNT_ONE;
          end
        end

        default: begin
          state   <= IDLE;
          md_cnt  <= '0;
          md_busy <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef PIPE_CTRL_STATS_EN
  // stall_cycles counts real pipeline holds. Cycles where a request overrides
  // the stall are not holds, so they are not counted. It saturates so that
  // a long run cannot wrap it back to a small, misleading value.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      req_count    <= '0;
    end else begin
      if (E_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (exc_req) begin
        req_count <= req_count + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
